// File: rtl/ripple_count_sampler.sv
// Samples an asynchronous ripple down-counter bus, debounces ripple transients and tracks underflows.
// Optional skip-error detection is compiled in when SAMPLER_SKIP_CHECK_EN is defined.
module ripple_count_sampler #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic [WIDTH-1:0] CountIn,
    input  logic             ClrCnt,
    output logic [WIDTH-1:0] CountOut,
    output logic             CountValid,
    output logic             UnderflowPulse,
    output logic [7:0]       UnderflowTotal,
    output logic             SkipErr
);

    typedef enum logic [1:0] {INIT, STABLE, SETTLE} state_t;

    localparam logic [3:0] STABLE_TGT = 4'(STABLE_CYCLES);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [3:0]       stab_q, stab_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             uf_pulse_q, uf_pulse_d;
    logic [7:0]       uf_total_q, uf_total_d;
`ifdef SAMPLER_SKIP_CHECK_EN
    logic             skip_q, skip_d;
`endif

    logic             trk_match;
    logic [WIDTH-1:0] trk_cand;
    logic [3:0]       trk_stab;
    logic             trk_accept;
    logic             do_eval;
    logic [WIDTH-1:0] prev_val;
    logic [7:0]       uf_base;

    // Candidate tracker shared by INIT and SETTLE: a mismatch restarts the run at 1.
    always_comb begin
        trk_match  = (sync2_q == cand_q);
        trk_cand   = sync2_q;
        trk_stab   = trk_match ? (stab_q + 4'd1) : 4'd1;
        trk_accept = (trk_stab == STABLE_TGT);
    end

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        stab_d     = stab_q;
        count_d    = count_q;
        valid_d    = valid_q;
        uf_pulse_d = 1'b0;
        uf_base    = ClrCnt ? 8'd0 : uf_total_q;
        uf_total_d = uf_base;
`ifdef SAMPLER_SKIP_CHECK_EN
        skip_d     = ClrCnt ? 1'b0 : skip_q;
`endif
        do_eval    = 1'b0;
        prev_val   = count_q - 1'b1;

        unique case (state_q)
            INIT: begin
                cand_d = trk_cand;
                stab_d = trk_stab;
                if (trk_accept) begin
                    // First acceptance has no history, so it is never judged as a step.
                    count_d = trk_cand;
                    valid_d = 1'b1;
                    state_d = STABLE;
                end
            end
            STABLE: begin
                if (sync2_q != count_q) begin
                    cand_d = sync2_q;
                    stab_d = 4'd1;
                    if (STABLE_TGT == 4'd1) do_eval = 1'b1;
                    else                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                cand_d = trk_cand;
                stab_d = trk_stab;
                if (trk_accept) begin
                    do_eval = 1'b1;
                    state_d = STABLE;
                end
            end
            default: state_d = INIT;
        endcase

        // Set wins over a same-cycle ClrCnt because the clear is already folded into the bases.
        if (do_eval) begin
            count_d = sync2_q;
            if (sync2_q == prev_val) begin
                if (count_q == '0) begin
                    uf_pulse_d = 1'b1;
                    uf_total_d = (uf_base == 8'hFF) ? 8'hFF : uf_base + 8'd1;
                end
            end
`ifdef SAMPLER_SKIP_CHECK_EN
            else if (sync2_q != count_q) begin
                skip_d = 1'b1;
            end
`endif
        end
    end

    // NOTE: every flop uses non-blocking assignment so all registers update from pre-edge values.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q    <= INIT;
            sync1_q    <= '0;
            sync2_q    <= '0;
            cand_q     <= '0;
            stab_q     <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            uf_pulse_q <= 1'b0;
            uf_total_q <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= CountIn;
            sync2_q    <= sync1_q;
            cand_q     <= cand_d;
            stab_q     <= stab_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            uf_pulse_q <= uf_pulse_d;
            uf_total_q <= uf_total_d;
        end
    end

`ifdef SAMPLER_SKIP_CHECK_EN
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) skip_q <= 1'b0;
        else     skip_q <= skip_d;
    end
    assign SkipErr = skip_q;
`else
    assign SkipErr = 1'b0;
`endif

    assign CountOut       = count_q;
    assign CountValid     = valid_q;
    assign UnderflowPulse = uf_pulse_q;
    assign UnderflowTotal = uf_total_q;

endmodule
